reset_sequencer: RTL
====================

# reset_sequencer

Consumes the active-high system reset produced by the power-up/button reset generator and releases downstream subsystem resets one stage at a time, in fixed order. Each released stage must report ready before the next stage is released, with a per-stage timeout. It sits directly after the reset generator in the top level and drives the per-subsystem reset lines.

## Interface

- STAGES, 4, number of sequenced reset outputs (1..8)
- IDX_WIDTH, 2, width of stage index; must satisfy 2^IDX_WIDTH >= STAGES
- HOLD_CYCLES, 15, consecutive cycles i_rst_req must be low before stage 0 is released (>=1)
- HOLD_WIDTH, 4, hold counter width; must represent HOLD_CYCLES-1
- TIMEOUT_CYCLES, 255, cycles allowed per stage for ready (>=1)
- TIMEOUT_WIDTH, 8, timeout counter width; must represent TIMEOUT_CYCLES-1

- clk  input  1  single clock; all logic on rising edge
- i_rst_n  input  1  synchronous, active-low block reset
- i_rst_req  input  1  active-high reset request from the reset generator, same clock domain, no synchroniser
- i_stage_ready  input  STAGES  bit k high = stage k out of reset and ready
- o_stage_rst  output  STAGES  active-high reset to stage k
- o_done  output  1  all stages released and ready
- o_timeout_err  output  1  sticky: a stage failed to become ready in time
- o_stage_idx  output  IDX_WIDTH  stage currently being waited on / failed

## Operation

- States: ASSERT, WAIT_READY, RUN, ERROR.
- i_rst_n low (highest priority): state ASSERT, o_stage_rst all ones, o_done 0, o_timeout_err 0, o_stage_idx 0, both counters 0.
- ASSERT: all stages held in reset. Hold counter clears whenever i_rst_req sampled high; increments while low. Edge sampling i_rst_req low with hold counter == HOLD_CYCLES-1: o_stage_rst[0] <= 0, o_stage_idx <= 0, timeout counter <= 0, -> WAIT_READY.
- WAIT_READY(k): i_stage_ready[k] sampled high: if k == STAGES-1, -> RUN, o_done <= 1; else o_stage_rst[k+1] <= 0, o_stage_idx <= k+1, timeout counter <= 0. Ready low: timeout counter increments; if it equals TIMEOUT_CYCLES-1 at that edge, -> ERROR, o_stage_rst[k] <= 1, o_timeout_err <= 1, o_stage_idx holds k.
- Only i_stage_ready[o_stage_idx] is examined; other ready bits ignored in all states.
- RUN: outputs static; ready drops are ignored.
- ERROR: stages < k remain released, stages >= k in reset; stays until i_rst_req or i_rst_n.
- i_rst_req sampled high in WAIT_READY, RUN or ERROR: next edge -> ASSERT, o_stage_rst all ones, o_done 0, o_timeout_err 0, o_stage_idx 0, counters 0.
- i_rst_req high in same cycle as ready or timeout: reset request wins.
- Counters never wrap: each is compared and cleared before reaching its limit.

## Timing

- All outputs registered; no combinational input-to-output path.
- Release latency: o_stage_rst[0] falls at the HOLD_CYCLES-th consecutive edge sampling i_rst_req low (15 with defaults).
- Stage-to-stage: o_stage_rst[k+1] falls on the same edge that samples i_stage_ready[k] high.
- o_done rises on the edge sampling the last stage's ready high.
- Timeout: ERROR entered on the TIMEOUT_CYCLES-th consecutive edge sampling ready low after release.
- Reset request abort: one-cycle latency to full re-assertion.

## Structure

- Package reset_seq_pkg: state encoding localparams (ASSERT, WAIT_READY, RUN, ERROR, 2-bit).
- Sub-module reset_seq_timer: parameterised width counter with clear, enable, and terminal-compare output; instantiated for hold and timeout counts.
- Top: FSM, stage index register, o_stage_rst vector register.

## Test plan

- i_rst_n low then high, i_rst_req low -> o_stage_rst 4'b1111 until 15th edge, then 4'b1110; o_done 0.
- Each stage raises ready 3 cycles after its release -> o_stage_rst 1110, 1100, 1000, 0000 at 3-cycle spacing; o_done 1 on the edge sampling ready[3].
- i_rst_req pulses high for 1 cycle at hold count 10 -> hold restarts; stage 0 released 15 edges after the pulse ends.
- Stage 2 never ready -> 255 edges after its release: o_timeout_err 1, o_stage_idx 2, o_stage_rst 4'b1100.
- In RUN, i_rst_req high 1 cycle -> next edge o_stage_rst 4'b1111, o_done 0; full sequence repeats.
- i_stage_ready[1] high while waiting on stage 0, and i_rst_req high on the same edge as ready[3] -> no advance; second case returns to ASSERT, o_done stays 0.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared state encoding for the staged reset sequencer.
package reset_seq_pkg;

    localparam logic [1:0] ENC_ASSERT     = 2'd0;
    localparam logic [1:0] ENC_WAIT_READY = 2'd1;
    localparam logic [1:0] ENC_RUN        = 2'd2;
    localparam logic [1:0] ENC_ERROR      = 2'd3;

    typedef enum logic [1:0] {
        ASSERT     = ENC_ASSERT,
        WAIT_READY = ENC_WAIT_READY,
        RUN        = ENC_RUN,
        ERROR      = ENC_ERROR
    } seq_state_t;

endpackage

// File: rtl/reset_seq_timer.sv
// Up-counter with clear/enable; o_term flags the last count before LIMIT.
module reset_seq_timer #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_term
);

    logic [WIDTH-1:0] r_count;

    // Clear has priority so the owner can restart the count on the terminal edge.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_term = (r_count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/reset_sequencer.sv
// Releases per-subsystem resets in order, waiting for each stage's ready with a timeout.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int STAGES         = 4,
    parameter int IDX_WIDTH      = 2,
    parameter int HOLD_CYCLES    = 15,
    parameter int HOLD_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_rst_req,
    input  logic [STAGES-1:0]    i_stage_ready,
    output logic [STAGES-1:0]    o_stage_rst,
    output logic                 o_done,
    output logic                 o_timeout_err,
    output logic [IDX_WIDTH-1:0] o_stage_idx
);

    seq_state_t           r_state, w_state_nxt;
    logic [STAGES-1:0]    r_stage_rst, w_stage_rst_nxt;
    logic [IDX_WIDTH-1:0] r_idx, w_idx_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_err, w_err_nxt;

    logic w_hold_clr, w_hold_en, w_hold_term;
    logic w_to_clr, w_to_en, w_to_term;
    logic w_ready_sel;

    reset_seq_timer #(.WIDTH(HOLD_WIDTH), .LIMIT(HOLD_CYCLES)) u_hold (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_hold_clr),
        .i_en    (w_hold_en),
        .o_term  (w_hold_term)
    );

    reset_seq_timer #(.WIDTH(TIMEOUT_WIDTH), .LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_to_clr),
        .i_en    (w_to_en),
        .o_term  (w_to_term)
    );

    // Only the ready bit of the stage being waited on matters.
    always_comb begin
        w_ready_sel = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (r_idx == IDX_WIDTH'(k)) w_ready_sel = i_stage_ready[k];
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_stage_rst_nxt = r_stage_rst;
        w_idx_nxt       = r_idx;
        w_done_nxt      = r_done;
        w_err_nxt       = r_err;
        w_hold_clr      = 1'b1;
        w_hold_en       = 1'b0;
        w_to_clr        = 1'b1;
        w_to_en         = 1'b0;

        if (i_rst_req) begin
            w_state_nxt     = ASSERT;
            w_stage_rst_nxt = '1;
            w_idx_nxt       = '0;
            w_done_nxt      = 1'b0;
            w_err_nxt       = 1'b0;
        end else begin
            case (r_state)
                ASSERT: begin
                    w_stage_rst_nxt = '1;
                    if (w_hold_term) begin
                        w_stage_rst_nxt[0] = 1'b0;
                        w_idx_nxt          = '0;
                        w_state_nxt        = WAIT_READY;
                    end else begin
                        w_hold_clr = 1'b0;
                        w_hold_en  = 1'b1;
                    end
                end
                WAIT_READY: begin
                    if (w_ready_sel) begin
                        if (r_idx == IDX_WIDTH'(STAGES - 1)) begin
                            w_state_nxt = RUN;
                            w_done_nxt  = 1'b1;
                        end else begin
                            for (int k = 0; k < STAGES; k++) begin
                                if (k == int'(r_idx) + 1) w_stage_rst_nxt[k] = 1'b0;
                            end
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end else if (w_to_term) begin
                        // Put the failing stage back into reset; index keeps pointing at it.
                        for (int k = 0; k < STAGES; k++) begin
                            if (k == int'(r_idx)) w_stage_rst_nxt[k] = 1'b1;
                        end
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ERROR;
                    end else begin
                        w_to_clr = 1'b0;
                        w_to_en  = 1'b1;
                    end
                end
                RUN:     ;
                ERROR:   ;
                default: w_state_nxt = ASSERT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_state     <= ASSERT;
            r_stage_rst <= '1;
            r_idx       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_stage_rst <= w_stage_rst_nxt;
            r_idx       <= w_idx_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign o_stage_rst   = r_stage_rst;
    assign o_done        = r_done;
    assign o_timeout_err = r_err;
    assign o_stage_idx   = r_idx;

endmodule
